tmds_video_encoder: RTL and testbench
=====================================

# tmds_video_encoder

Single-clock, three-channel TMDS encoder for the pixel-clock domain of the HDMI output path. It turns one pixel per cycle (8-bit R/G/B plus DE and syncs) into three 10-bit TMDS symbols per cycle, for an external 10:1 serializer. It adds HDMI video preamble and leading guard-band insertion through a 10-cycle look-ahead delay line, plus configurable sync polarity. With HDMI_MODE=0 it produces plain DVI.

## Interface
Parameters:
- HDMI_MODE, 1: 1 inserts the 8-cycle video preamble and the 2-cycle guard band before each active run; 0 sends plain DVI control periods.
- SYNC_INVERT, 1: 1 inverts hsync/vsync before control encoding, for active-low timing generators.

Ports:
- clk  in  1  pixel clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- vde  in  1  active video area.
- hsync  in  1  horizontal sync.
- vsync  in  1  vertical sync.
- pix_r, pix_g, pix_b  in  8 each  pixel data.
- tmds_ch0, tmds_ch1, tmds_ch2  out  10 each  registered symbols for blue, green and red; bit 0 is transmitted first.

## Operation
- **Delay line.** {vde, hsync, vsync, pix} pass through a 10-stage delay; the delayed copies are d_*. Raw vde is the look-ahead `look`.
- **Video encoding.** When d_vde=1, each channel performs DVI 1.0 8b/10b encoding.
  - Transition stage: XNOR if N1(D)>4, or if N1(D)=4 and D[0]=0; otherwise XOR. q_m[8]=1 for XOR.
  - DC balance: the standard three-case rule with a per-channel signed 5-bit running disparity `cnt`.
- **Disparity reset.** `cnt` clears to 0 on every cycle with d_vde=0.
- **Control symbols.** 00→1101010100, 01→0010101011, 10→0101010100, 11→1010101011 (written bit9..bit0).
  - ch0 carries {s_vsync, s_hsync}, where s_x = d_x ^ SYNC_INVERT.
  - ch1 carries {CTL1, CTL0}; ch2 carries {CTL3, CTL2}.
- **FSM** (meaningful only when HDMI_MODE=1; with HDMI_MODE=0 the state stays CTRL):
  - CTRL: CTL all 0. A rising edge of `look` (look=1, previous look=0) moves to PRE with k=0.
  - PRE: ch1 CTL = 01, ch2 CTL = 00. k increments each cycle; at k=7 move to GUARD.
  - GUARD: ch0=1011001100, ch1=0100110011, ch2=1011001100. At k=9 move to CTRL.
  - A `look` rising edge in any state forces PRE with k=0.
- **Output priority.** d_vde=1 selects video symbols, else GUARD symbols, else control symbols.
  - When blanking is shorter than 10 cycles, the preamble is truncated from its start. Guard still occupies the last 2 blanking cycles if blanking ≥2.
- **Reset values.**
  - All delay stages 0, state CTRL, k=0, `cnt`=0.
  - All three outputs = 1101010100, regardless of SYNC_INVERT.

## Timing
- Latency from input to output symbol is 11 cycles in both modes: 10 cycles of delay plus 1 output register.
- With a `look` rise at input cycle t and blanking ≥10 cycles:
  - Preamble appears on outputs at t+1..t+8.
  - Guard band at t+9..t+10.
  - First video symbol, for input t, at t+11.
- A vde fall at input t gives a control symbol at t+11, and `cnt`=0 for the next active run.
- rst asserted at cycle t: the t+1 outputs are the reset values. No stale delay-line content is emitted afterwards.

## Structure
- Shared package `tmds_pkg`:
  - The four control symbol constants and the three guard-band constants.
  - FSM state enum {CTRL, PRE, GUARD}.
  - Constants PREAMBLE_LEN=8, GUARD_LEN=2, LOOKAHEAD=10.
- Sub-module `tmds_channel_encoder`, instantiated three times. It holds the 8b/10b logic, the disparity register and the control/guard mux.
- The top level owns the delay line and the FSM.

## Test plan
- **Reset:** rst high 3 cycles → all outputs 1101010100 on each of those cycles. Release with vde=0, hsync=vsync=1, SYNC_INVERT=1 → ch0 holds 1101010100.
- **Disparity sequence:** HDMI_MODE=0, 20 blank cycles, then vde=1 with pix_b=8'h00 held → ch0 symbols 0100000000, 1111111111, 0100000000, 1111111111. Internal `cnt` = -8, 2, -6, 4.
- **Preamble and guard:** HDMI_MODE=1, 20 blank cycles, vde rises at input t → ch1=0010101011 and ch2=1101010100 at t+1..t+8. Guard on all channels at t+9..t+10. Video at t+11.
- **Short blanking:** active run, 4 blank cycles, active again → exactly 2 preamble symbols, then 2 guard symbols, then video. No gap, no duplicate.
- **Disparity reset between runs:** two active runs of pix_b=8'h00, each 3 cycles long, 12 blank cycles apart → the second run starts again at 0100000000 (`cnt` reset).
- **Reset mid-preamble:** assert rst at t+4 during PRE → output at t+5 is 1101010100 on all channels. Then outputs stay control-only until a new vde rise; the pending video run is never emitted.

Source files
------------

// File: rtl/tmds_pkg.sv
// tmds_pkg: shared constants, types and helpers for the TMDS video encoder.
//   - Control-period and guard-band symbols (written bit9..bit0, bit 0 sent first)
//   - Preamble / guard / look-ahead lengths
//   - FSM state enum and the delay-line record type
package tmds_pkg;

  localparam int PREAMBLE_LEN = 8;
  localparam int GUARD_LEN    = 2;
  localparam int LOOKAHEAD    = PREAMBLE_LEN + GUARD_LEN;

  // Phase counter values at which the FSM leaves PRE and GUARD
  localparam logic [3:0] K_PRE_LAST   = 4'(PREAMBLE_LEN - 1);
  localparam logic [3:0] K_GUARD_LAST = 4'(LOOKAHEAD - 1);

  localparam logic [9:0] CTRL_SYM_00 = 10'b1101010100;
  localparam logic [9:0] CTRL_SYM_01 = 10'b0010101011;
  localparam logic [9:0] CTRL_SYM_10 = 10'b0101010100;
  localparam logic [9:0] CTRL_SYM_11 = 10'b1010101011;

  localparam logic [9:0] GUARD_SYM_CH0 = 10'b1011001100;
  localparam logic [9:0] GUARD_SYM_CH1 = 10'b0100110011;
  localparam logic [9:0] GUARD_SYM_CH2 = 10'b1011001100;

  typedef enum logic [1:0] {
    CTRL  = 2'd0,
    PRE   = 2'd1,
    GUARD = 2'd2
  } state_e;

  // One delay-line entry; syncs are held already polarity-corrected
  typedef struct packed {
    logic       vde;
    logic       s_vsync;
    logic       s_hsync;
    logic [7:0] red;
    logic [7:0] green;
    logic [7:0] blue;
  } pix_stage_t;

  function automatic logic [9:0] ctrl_symbol(input logic [1:0] c);
    logic [9:0] sym;
    case (c)
      2'b00:   sym = CTRL_SYM_00;
      2'b01:   sym = CTRL_SYM_01;
      2'b10:   sym = CTRL_SYM_10;
      2'b11:   sym = CTRL_SYM_11;
      default: sym = CTRL_SYM_00;
    endcase
    return sym;
  endfunction

  function automatic logic [3:0] ones8(input logic [7:0] d);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'd0, d[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/tmds_channel_encoder.sv
// tmds_channel_encoder: one TMDS lane. DVI 8b/10b video coding with running
// disparity, plus the control / guard-band symbol mux, behind an output register.
//   clk, rst   pixel clock, synchronous active-high reset
//   vde_i      delayed active-video flag (selects video coding)
//   data_i     delayed 8-bit component
//   ctl_i      2-bit control code used outside video and guard
//   guard_i    guard-band phase (used when vde_i is low)
//   sym_o      registered 10-bit symbol, bit 0 transmitted first
module tmds_channel_encoder
  import tmds_pkg::*;
#(
  parameter logic [9:0] GUARD_SYM = GUARD_SYM_CH0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vde_i,
  input  logic [7:0] data_i,
  input  logic [1:0] ctl_i,
  input  logic       guard_i,
  output logic [9:0] sym_o
);

  logic [3:0]        n1_data_s;
  logic              use_xnor_s;
  logic [8:0]        q_m_s;
  logic [3:0]        n1_qm_s;
  logic [3:0]        n0_qm_s;
  logic signed [4:0] diff_s;
  logic [9:0]        vid_sym_s;
  logic signed [4:0] vid_cnt_s;
  logic signed [4:0] cnt_q, cnt_d;
  logic [9:0]        sym_q, sym_d;

  // Transition-minimising stage and DC-balance selection for video data
  always_comb begin
    n1_data_s  = ones8(data_i);
    use_xnor_s = (n1_data_s > 4'd4) || ((n1_data_s == 4'd4) && (data_i[0] == 1'b0));
    q_m_s      = 9'd0;
    q_m_s[0]   = data_i[0];
    for (int i = 1; i < 8; i++) begin
      if (use_xnor_s) begin
        q_m_s[i] = ~(q_m_s[i-1] ^ data_i[i]);
      end else begin
        q_m_s[i] = q_m_s[i-1] ^ data_i[i];
      end
    end
    q_m_s[8] = ~use_xnor_s;
    n1_qm_s  = ones8(q_m_s[7:0]);
    n0_qm_s  = 4'd8 - n1_qm_s;
    // diff_s is N1 - N0 of the 8 data bits of q_m
    diff_s   = $signed({1'b0, n1_qm_s}) - $signed({1'b0, n0_qm_s});
    if ((cnt_q == 5'sd0) || (n1_qm_s == n0_qm_s)) begin
      vid_sym_s = {~q_m_s[8], q_m_s[8], (q_m_s[8] ? q_m_s[7:0] : ~q_m_s[7:0])};
      if (q_m_s[8]) begin
        vid_cnt_s = cnt_q + diff_s;
      end else begin
        vid_cnt_s = cnt_q - diff_s;
      end
    end else if (((cnt_q > 5'sd0) && (n1_qm_s > n0_qm_s)) ||
                 ((cnt_q < 5'sd0) && (n0_qm_s > n1_qm_s))) begin
      vid_sym_s = {1'b1, q_m_s[8], ~q_m_s[7:0]};
      vid_cnt_s = cnt_q + $signed({3'b000, q_m_s[8], 1'b0}) - diff_s;
    end else begin
      vid_sym_s = {1'b0, q_m_s[8], q_m_s[7:0]};
      vid_cnt_s = cnt_q - $signed({3'b000, ~q_m_s[8], 1'b0}) + diff_s;
    end
  end

  // Output priority: video, then guard band, then control; disparity clears outside video
  always_comb begin
    sym_d = ctrl_symbol(ctl_i);
    cnt_d = 5'sd0;
    if (vde_i) begin
      sym_d = vid_sym_s;
      cnt_d = vid_cnt_s;
    end else if (guard_i) begin
      sym_d = GUARD_SYM;
    end else begin
      sym_d = ctrl_symbol(ctl_i);
    end
  end

  // Symbol and running-disparity registers
  always_ff @(posedge clk) begin
    if (rst) begin
      sym_q <= CTRL_SYM_00;
      cnt_q <= 5'sd0;
    end else begin
      sym_q <= sym_d;
      cnt_q <= cnt_d;
    end
  end

  assign sym_o = sym_q;

endmodule

// File: rtl/tmds_video_encoder.sv
// tmds_video_encoder: three-lane TMDS encoder for the pixel-clock domain.
// A 10-stage delay line gives the FSM look-ahead on vde so the HDMI video
// preamble (8 cycles) and leading guard band (2 cycles) end exactly where
// the delayed active run begins.
//   clk, rst                 pixel clock, synchronous active-high reset
//   vde, hsync, vsync        active video and syncs
//   pix_r, pix_g, pix_b      8-bit pixel components
//   tmds_ch0/1/2             registered symbols for blue / green / red
module tmds_video_encoder
  import tmds_pkg::*;
#(
  parameter bit HDMI_MODE   = 1'b1,
  parameter bit SYNC_INVERT = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vde,
  input  logic       hsync,
  input  logic       vsync,
  input  logic [7:0] pix_r,
  input  logic [7:0] pix_g,
  input  logic [7:0] pix_b,
  output logic [9:0] tmds_ch0,
  output logic [9:0] tmds_ch1,
  output logic [9:0] tmds_ch2
);

  pix_stage_t stage_in_s;
  pix_stage_t dly_q [LOOKAHEAD];
  pix_stage_t d_s;
  logic       look_q;
  logic       rise_s;
  state_e     state_q, state_d, cur_state_s;
  logic [3:0] k_q, k_d, cur_k_s;
  logic [1:0] ctl0_s, ctl1_s, ctl2_s;
  logic       guard_s;

  // Syncs enter the delay line already polarity-corrected, so the all-zero
  // reset content decodes as inactive sync for either SYNC_INVERT setting
  always_comb begin
    stage_in_s.vde     = vde;
    stage_in_s.s_vsync = vsync ^ SYNC_INVERT;
    stage_in_s.s_hsync = hsync ^ SYNC_INVERT;
    stage_in_s.red     = pix_r;
    stage_in_s.green   = pix_g;
    stage_in_s.blue    = pix_b;
  end

  // Look-ahead delay line and previous-look register
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LOOKAHEAD; i++) begin
        dly_q[i] <= '0;
      end
      look_q <= 1'b0;
    end else begin
      dly_q[0] <= stage_in_s;
      for (int i = 1; i < LOOKAHEAD; i++) begin
        dly_q[i] <= dly_q[i-1];
      end
      look_q <= vde;
    end
  end

  assign d_s = dly_q[LOOKAHEAD-1];

  // FSM next state; a look rise acts in its own cycle so the first preamble
  // symbol is registered on the same edge that captures the rising vde
  always_comb begin
    rise_s      = HDMI_MODE && vde && !look_q;
    cur_state_s = state_q;
    cur_k_s     = k_q;
    if (rise_s) begin
      cur_state_s = PRE;
      cur_k_s     = 4'd0;
    end else begin
      cur_state_s = state_q;
      cur_k_s     = k_q;
    end
    state_d = cur_state_s;
    k_d     = 4'd0;
    case (cur_state_s)
      CTRL: begin
        state_d = CTRL;
        k_d     = 4'd0;
      end
      PRE: begin
        k_d = cur_k_s + 4'd1;
        if (cur_k_s == K_PRE_LAST) begin
          state_d = GUARD;
        end else begin
          state_d = PRE;
        end
      end
      GUARD: begin
        if (cur_k_s == K_GUARD_LAST) begin
          state_d = CTRL;
          k_d     = 4'd0;
        end else begin
          state_d = GUARD;
          k_d     = cur_k_s + 4'd1;
        end
      end
      default: begin
        state_d = CTRL;
        k_d     = 4'd0;
      end
    endcase
  end

  // FSM state and phase counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CTRL;
      k_q     <= 4'd0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
    end
  end

  // Per-lane control codes and guard select for the current phase
  always_comb begin
    ctl0_s = {d_s.s_vsync, d_s.s_hsync};
    ctl2_s = 2'b00;
    if (cur_state_s == PRE) begin
      ctl1_s = 2'b01;
    end else begin
      ctl1_s = 2'b00;
    end
    guard_s = (cur_state_s == GUARD);
  end

  tmds_channel_encoder #(.GUARD_SYM(GUARD_SYM_CH0)) u_ch0 (
    .clk    (clk),
    .rst    (rst),
    .vde_i  (d_s.vde),
    .data_i (d_s.blue),
    .ctl_i  (ctl0_s),
    .guard_i(guard_s),
    .sym_o  (tmds_ch0)
  );

  tmds_channel_encoder #(.GUARD_SYM(GUARD_SYM_CH1)) u_ch1 (
    .clk    (clk),
    .rst    (rst),
    .vde_i  (d_s.vde),
    .data_i (d_s.green),
    .ctl_i  (ctl1_s),
    .guard_i(guard_s),
    .sym_o  (tmds_ch1)
  );

  tmds_channel_encoder #(.GUARD_SYM(GUARD_SYM_CH2)) u_ch2 (
    .clk    (clk),
    .rst    (rst),
    .vde_i  (d_s.vde),
    .data_i (d_s.red),
    .ctl_i  (ctl2_s),
    .guard_i(guard_s),
    .sym_o  (tmds_ch2)
  );

endmodule

// File: tb/tb_tmds_video_encoder.sv
// Bench for tmds_video_encoder: a DVI instance (HDMI_MODE=0, SYNC_INVERT=0)
// and an HDMI instance (HDMI_MODE=1, SYNC_INVERT=1) share one stimulus stream.
// Expected symbols come from an input-history model: output after edge n is
// derived from the input 10 cycles earlier and the distance to the latest
// vde rise; plus directed spot checks of literal symbols.
module tb_tmds_video_encoder;

  localparam int MAXC = 4096;
  localparam logic [9:0] C00 = 10'b1101010100;
  localparam logic [9:0] C01 = 10'b0010101011;
  localparam logic [9:0] C10 = 10'b0101010100;
  localparam logic [9:0] C11 = 10'b1010101011;
  localparam logic [9:0] G02 = 10'b1011001100;
  localparam logic [9:0] G1  = 10'b0100110011;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, vde, hsync, vsync;
  logic [7:0] pix_r, pix_g, pix_b;
  logic [9:0] a_ch0, a_ch1, a_ch2, b_ch0, b_ch1, b_ch2;

  tmds_video_encoder #(.HDMI_MODE(1'b0), .SYNC_INVERT(1'b0)) dut_dvi (
    .clk(clk), .rst(rst), .vde(vde), .hsync(hsync), .vsync(vsync),
    .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
    .tmds_ch0(a_ch0), .tmds_ch1(a_ch1), .tmds_ch2(a_ch2));

  tmds_video_encoder #(.HDMI_MODE(1'b1), .SYNC_INVERT(1'b1)) dut_hdmi (
    .clk(clk), .rst(rst), .vde(vde), .hsync(hsync), .vsync(vsync),
    .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
    .tmds_ch0(b_ch0), .tmds_ch1(b_ch1), .tmds_ch2(b_ch2));

  // input history, indexed by edge number
  bit         h_rst [MAXC];
  bit         h_vde [MAXC];
  bit         h_hs  [MAXC];
  bit         h_vs  [MAXC];
  logic [7:0] h_pix [MAXC][3];

  int         cyc = 0;
  int         n_checks = 0;
  int         n_pass = 0;
  int         n_fail = 0;
  int         cnt_m [6];
  logic [9:0] exp_m [6];

  // directed checks scheduled for a given edge; sel = dut*3 + channel
  int         sq_edge [$];
  int         sq_sel  [$];
  logic [9:0] sq_val  [$];
  string      sq_tag  [$];

  function automatic logic [9:0] ctl_sym(input logic [1:0] c);
    case (c)
      2'b00:   return C00;
      2'b01:   return C01;
      2'b10:   return C10;
      default: return C11;
    endcase
  endfunction

  function automatic bit rst_at(input int m);
    if (m < 0) return 1'b1;
    return h_rst[m];
  endfunction

  function automatic logic [9:0] obs_sym(input int sel);
    case (sel)
      0:       return a_ch0;
      1:       return a_ch1;
      2:       return a_ch2;
      3:       return b_ch0;
      4:       return b_ch1;
      default: return b_ch2;
    endcase
  endfunction

  // DVI 1.0 8b/10b for one byte given the running disparity
  task automatic enc_video(input logic [7:0] d, input int cnt_in,
                           output logic [9:0] sym, output int cnt_out);
    int ones_d, ones_q, zeros_q, q8;
    bit inv;
    logic [8:0] qm;
    ones_d = $countones(d);
    inv = (ones_d > 4) || (ones_d == 4 && d[0] == 1'b0);
    qm = 9'd0;
    qm[0] = d[0];
    for (int i = 1; i < 8; i++) qm[i] = inv ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
    qm[8] = ~inv;
    q8 = inv ? 0 : 1;
    ones_q = $countones(qm[7:0]);
    zeros_q = 8 - ones_q;
    if (cnt_in == 0 || ones_q == zeros_q) begin
      sym = {~qm[8], qm[8], (qm[8] ? qm[7:0] : ~qm[7:0])};
      cnt_out = (q8 == 1) ? cnt_in + ones_q - zeros_q : cnt_in + zeros_q - ones_q;
    end else if ((cnt_in > 0 && ones_q > zeros_q) || (cnt_in < 0 && zeros_q > ones_q)) begin
      sym = {1'b1, qm[8], ~qm[7:0]};
      cnt_out = cnt_in + 2 * q8 + zeros_q - ones_q;
    end else begin
      sym = {1'b0, qm[8], qm[7:0]};
      cnt_out = cnt_in - 2 * (1 - q8) + ones_q - zeros_q;
    end
  endtask

  // expected outputs after edge n
  task automatic model_edge(input int n);
    bit dv, s_hs, s_vs;
    int src, p, c, sel;
    logic [9:0] sym;
    src = n - 10;
    dv = 1'b1;
    for (int m = n - 10; m < n; m++) if (rst_at(m)) dv = 1'b0;
    if (h_rst[n]) begin
      for (int s = 0; s < 6; s++) begin
        exp_m[s] = C00;
        cnt_m[s] = 0;
      end
    end else begin
      p = -1;
      for (int r = n; r > n - 10; r--) begin
        if (rst_at(r)) break;
        if (h_vde[r] && (rst_at(r - 1) || !h_vde[r - 1])) begin
          p = n - r;
          break;
        end
      end
      for (int d = 0; d < 2; d++) begin
        for (int ch = 0; ch < 3; ch++) begin
          sel = d * 3 + ch;
          if (dv && h_vde[src]) begin
            enc_video(h_pix[src][ch], cnt_m[sel], sym, c);
            exp_m[sel] = sym;
            cnt_m[sel] = c;
          end else begin
            cnt_m[sel] = 0;
            if (d == 1 && p >= 8) begin
              exp_m[sel] = (ch == 1) ? G1 : G02;
            end else if (ch == 0) begin
              s_hs = dv ? (h_hs[src] ^ (d == 1)) : 1'b0;
              s_vs = dv ? (h_vs[src] ^ (d == 1)) : 1'b0;
              exp_m[sel] = ctl_sym({s_vs, s_hs});
            end else if (ch == 1 && d == 1 && p >= 0) begin
              exp_m[sel] = C01;
            end else begin
              exp_m[sel] = C00;
            end
          end
        end
      end
    end
  endtask

  task automatic check(input string tag, input logic [9:0] obs, input logic [9:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s edge %0d: observed %b expected %b", tag, cyc, obs, expv);
    end
  endtask

  task automatic expect_at(input int edge_n, input int sel, input logic [9:0] val, input string tag);
    sq_edge.push_back(edge_n);
    sq_sel.push_back(sel);
    sq_val.push_back(val);
    sq_tag.push_back(tag);
  endtask

  // one clock: record inputs, take the edge, compare model and scheduled checks
  task automatic step();
    int i;
    if (cyc >= MAXC) begin
      $display("FAIL cycle_budget: edge %0d reached limit %0d", cyc, MAXC);
      $fatal(1, "cycle budget exceeded");
    end
    h_rst[cyc] = rst;
    h_vde[cyc] = vde;
    h_hs[cyc]  = hsync;
    h_vs[cyc]  = vsync;
    h_pix[cyc][0] = pix_b;
    h_pix[cyc][1] = pix_g;
    h_pix[cyc][2] = pix_r;
    @(posedge clk);
    #1;
    model_edge(cyc);
    for (int s = 0; s < 6; s++) check($sformatf("model_%s_ch%0d", (s < 3) ? "dvi" : "hdmi", s % 3), obs_sym(s), exp_m[s]);
    i = 0;
    while (i < sq_edge.size()) begin
      if (sq_edge[i] == cyc) begin
        check(sq_tag[i], obs_sym(sq_sel[i]), sq_val[i]);
        sq_edge.delete(i);
        sq_sel.delete(i);
        sq_val.delete(i);
        sq_tag.delete(i);
      end else begin
        i++;
      end
    end
    cyc++;
  endtask

  function automatic logic [7:0] rnd_pix();
    case ($urandom_range(0, 5))
      0:       return 8'h00;
      1:       return 8'hFF;
      2:       return 8'h0F;
      default: return 8'($urandom);
    endcase
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached at edge %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int t, blank, act;
    rst = 1'b1; vde = 1'b0; hsync = 1'b1; vsync = 1'b1;
    pix_r = 8'h00; pix_g = 8'h00; pix_b = 8'h00;

    // reset: all lanes at the 00 control symbol
    for (int i = 0; i < 3; i++) begin
      for (int s = 0; s < 6; s++) expect_at(cyc, s, C00, "reset_value");
      step();
    end
    // release with syncs high and inverted polarity: ch0 stays at 00 symbol
    rst = 1'b0;
    for (int i = 0; i < 15; i++) begin
      expect_at(cyc, 3, C00, "release_ch0_hold");
      step();
    end

    // disparity sequence on DVI blue lane
    hsync = 1'b0; vsync = 1'b0;
    repeat (20) step();
    t = cyc; vde = 1'b1; pix_b = 8'h00;
    expect_at(t + 10, 0, 10'b0100000000, "disp_seq0");
    expect_at(t + 11, 0, 10'b1111111111, "disp_seq1");
    expect_at(t + 12, 0, 10'b0100000000, "disp_seq2");
    expect_at(t + 13, 0, 10'b1111111111, "disp_seq3");
    repeat (6) begin pix_g = rnd_pix(); pix_r = rnd_pix(); step(); end

    // full preamble and guard ahead of an active run
    vde = 1'b0;
    repeat (20) step();
    t = cyc; vde = 1'b1;
    for (int i = 0; i < 8; i++) begin
      expect_at(t + i, 4, C01, "preamble_ch1");
      expect_at(t + i, 5, C00, "preamble_ch2");
    end
    for (int i = 8; i < 10; i++) begin
      expect_at(t + i, 3, G02, "guard_ch0");
      expect_at(t + i, 4, G1,  "guard_ch1");
      expect_at(t + i, 5, G02, "guard_ch2");
    end
    repeat (12) begin pix_r = rnd_pix(); pix_g = rnd_pix(); pix_b = rnd_pix(); step(); end

    // short blanking: 2 preamble then 2 guard symbols
    vde = 1'b0;
    repeat (4) step();
    t = cyc; vde = 1'b1;
    expect_at(t + 6, 4, C01, "short_pre_a");
    expect_at(t + 7, 4, C01, "short_pre_b");
    expect_at(t + 8, 4, G1,  "short_guard_a");
    expect_at(t + 9, 4, G1,  "short_guard_b");
    repeat (12) begin pix_r = rnd_pix(); pix_g = rnd_pix(); pix_b = rnd_pix(); step(); end

    // disparity restarts from zero for each active run
    vde = 1'b0;
    repeat (15) step();
    for (int run = 0; run < 2; run++) begin
      t = cyc; vde = 1'b1; pix_b = 8'h00;
      expect_at(t + 10, 0, 10'b0100000000, "disp_reset0");
      expect_at(t + 11, 0, 10'b1111111111, "disp_reset1");
      expect_at(t + 12, 0, 10'b0100000000, "disp_reset2");
      repeat (3) step();
      vde = 1'b0;
      repeat (12) step();
    end

    // reset in the middle of a preamble drops the pending run
    t = cyc; vde = 1'b1;
    repeat (4) begin pix_r = rnd_pix(); pix_g = rnd_pix(); pix_b = rnd_pix(); step(); end
    rst = 1'b1; vde = 1'b0;
    for (int s = 0; s < 6; s++) expect_at(cyc, s, C00, "rst_mid_pre");
    step();
    rst = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      expect_at(cyc, 4, C00, "post_rst_ch1");
      expect_at(cyc, 5, C00, "post_rst_ch2");
      step();
    end

    // randomized traffic with occasional resets
    repeat (80) begin
      blank = $urandom_range(1, 14);
      hsync = 1'($urandom_range(0, 1));
      vsync = 1'($urandom_range(0, 1));
      vde = 1'b0;
      repeat (blank) begin
        if ($urandom_range(0, 7) == 0) hsync = ~hsync;
        step();
      end
      if ($urandom_range(0, 19) == 0) begin
        rst = 1'b1; step(); rst = 1'b0;
      end
      act = $urandom_range(1, 24);
      vde = 1'b1;
      repeat (act) begin
        pix_r = rnd_pix(); pix_g = rnd_pix(); pix_b = rnd_pix();
        step();
      end
    end
    vde = 1'b0;
    repeat (15) step();

    n_checks++;
    assert (sq_edge.size() === 0) n_pass++;
    else begin
      n_fail++;
      $error("FAIL sched_pending: observed %0d unchecked entries expected 0", sq_edge.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
